// File: rtl/display_scan_scheduler.sv
// rtl/display_scan_scheduler.sv - LED panel row/bit-plane scan sequencer (SHIFT->BLANK->LATCH->DISPLAY)
// Optional pulse-generator alignment checker: define DISPLAY_SCAN_SYNC_CHECK_EN.

module display_scan_scheduler #(
    parameter int ROWS         = 16,
    parameter int BITWIDTH     = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic                        shift_start,
    input  logic                        shift_done,
    output logic [$clog2(ROWS)-1:0]     shift_row,
    output logic [$clog2(BITWIDTH)-1:0] shift_plane,
    output logic                        pulse_go,
    input  logic                        pulse_complete,
    input  logic                        pulse_full_complete,
    input  logic [$clog2(BITWIDTH)-1:0] pulse_select,
    output logic [$clog2(ROWS)-1:0]     row_addr,
    output logic                        latch,
    output logic                        oe_n,
    output logic                        frame_done,
`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
    output logic                        sync_error,
`endif
    output logic                        busy
);

    localparam int RW = $clog2(ROWS);
    localparam int BW = $clog2(BITWIDTH);
    localparam int CW = $clog2(BLANK_CYCLES + 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [BW-1:0] PLANE_LAST = BW'(BITWIDTH - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   blank_cnt, blank_cnt_d;
    logic            shift_start_d, latch_d, frame_done_d, pulse_go_d, oe_n_d;
    logic [RW-1:0]   row_addr_d, shift_row_d;
    logic [BW-1:0]   shift_plane_d;
    logic            plane_wrap, row_wrap, display_done, frame_end;

    assign plane_wrap   = (shift_plane == PLANE_LAST);
    assign row_wrap     = (shift_row == ROW_LAST);
    assign display_done = (state == S_DISPLAY) && pulse_complete;
    assign frame_end    = display_done && plane_wrap && row_wrap;
    assign busy         = (state != S_IDLE);

`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
    logic mismatch, force_blank, force_blank_d;

    // shift_plane still holds the displayed plane until the completion edge
    assign mismatch      = display_done &&
                           ((pulse_select != shift_plane) || (pulse_full_complete != plane_wrap));
    assign force_blank_d = (force_blank || mismatch) && !frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            force_blank <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            force_blank <= force_blank_d;
            sync_error  <= sync_error || mismatch;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{pulse_select, pulse_full_complete};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        blank_cnt_d   = blank_cnt;
        shift_start_d = 1'b0;
        latch_d       = 1'b0;
        frame_done_d  = 1'b0;
        pulse_go_d    = pulse_go;
        oe_n_d        = oe_n;
        row_addr_d    = row_addr;
        shift_row_d   = shift_row;
        shift_plane_d = shift_plane;

        case (state)
            S_IDLE: begin
                oe_n_d     = 1'b1;
                pulse_go_d = 1'b0;
                if (enable) begin
                    state_d       = S_SHIFT;
                    shift_start_d = 1'b1;
                end
            end
            // oe_n is held so the previous plane stays lit while the next one shifts in
            S_SHIFT: begin
                if (shift_done) begin
                    state_d     = S_BLANK;
                    blank_cnt_d = '0;
                    oe_n_d      = 1'b1;
                end
            end
            S_BLANK: begin
                oe_n_d = 1'b1;
                if (blank_cnt == BLANK_LAST) begin
                    state_d    = S_LATCH;
                    latch_d    = 1'b1;
                    row_addr_d = shift_row;
                end else begin
                    blank_cnt_d = blank_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                state_d    = S_DISPLAY;
                pulse_go_d = 1'b1;
                oe_n_d     = 1'b0;
            end
            S_DISPLAY: begin
                if (pulse_complete) begin
                    pulse_go_d    = 1'b0;
                    shift_plane_d = plane_wrap ? '0 : shift_plane + 1'b1;
                    if (plane_wrap) begin
                        shift_row_d = row_wrap ? '0 : shift_row + 1'b1;
                    end
                    // enable is only honoured here so the generator plane index never slips
                    if (frame_end) begin
                        frame_done_d = 1'b1;
                        if (enable) begin
                            state_d       = S_SHIFT;
                            shift_start_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            oe_n_d  = 1'b1;
                        end
                    end else begin
                        state_d       = S_SHIFT;
                        shift_start_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
        if (force_blank_d) begin
            oe_n_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_cnt   <= '0;
            shift_start <= 1'b0;
            latch       <= 1'b0;
            frame_done  <= 1'b0;
            pulse_go    <= 1'b0;
            oe_n        <= 1'b1;
            row_addr    <= '0;
            shift_row   <= '0;
            shift_plane <= '0;
        end else begin
            blank_cnt   <= blank_cnt_d;
            shift_start <= shift_start_d;
            latch       <= latch_d;
            frame_done  <= frame_done_d;
            pulse_go    <= pulse_go_d;
            oe_n        <= oe_n_d;
            row_addr    <= row_addr_d;
            shift_row   <= shift_row_d;
            shift_plane <= shift_plane_d;
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb/tb_display_scan_scheduler.sv - scoreboard bench for display_scan_scheduler with shifter/generator models

module tb_display_scan_scheduler;

    localparam int ROWS   = 4;
    localparam int BITS   = 2;
    localparam int BLANK  = 2;
    localparam int PLANES = ROWS * BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       shift_start, shift_done;
    logic [1:0] shift_row;
    logic [0:0] shift_plane;
    logic       pulse_go, pulse_complete, pulse_full_complete;
    logic [0:0] pulse_select;
    logic [1:0] row_addr;
    logic       latch, oe_n, frame_done, busy;
`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
    logic       sync_error;
`endif

    display_scan_scheduler #(
        .ROWS(ROWS), .BITWIDTH(BITS), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .shift_start(shift_start), .shift_done(shift_done),
        .shift_row(shift_row), .shift_plane(shift_plane),
        .pulse_go(pulse_go), .pulse_complete(pulse_complete),
        .pulse_full_complete(pulse_full_complete), .pulse_select(pulse_select),
        .row_addr(row_addr), .latch(latch), .oe_n(oe_n), .frame_done(frame_done),
`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
        .sync_error(sync_error),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shifter model: shift_done comes sh_delay+1 cycles after the shift_start cycle
    int   sh_delay = 2;
    int   sh_cnt = 0;
    logic sh_busy = 1'b0;
    always @(posedge clk) begin
        if (rst) sh_busy <= 1'b0;
        else if (shift_start) begin
            sh_busy <= 1'b1;
            sh_cnt  <= sh_delay;
        end else if (sh_busy) begin
            if (sh_cnt == 0) sh_busy <= 1'b0;
            else sh_cnt <= sh_cnt - 1;
        end
    end
    assign shift_done = sh_busy && (sh_cnt == 0);

    // pulse generator model: DISPLAY lasts pulse_len+1 cycles
    int   pulse_len = 3;
    int   gen_cnt = 0;
    logic gen_plane = 1'b0;
    logic force_sel = 1'b0;
    always @(posedge clk) begin
        if (rst || !pulse_go) gen_cnt <= 0;
        else gen_cnt <= gen_cnt + 1;
        if (rst) gen_plane <= 1'b0;
        else if (pulse_complete) gen_plane <= ~gen_plane;
    end
    assign pulse_complete      = pulse_go && (gen_cnt == pulse_len);
    assign pulse_full_complete = pulse_complete && gen_plane;
    assign pulse_select        = force_sel ? 1'b1 : gen_plane;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard queues and monitor state
    int   exp_ss_q[$];
    int   exp_row_q[$];
    logic mon_en = 1'b0;
    int   exp_period = 0, exp_sl = 0;
    int   ss_cnt = 0, lat_cnt = 0, fd_cnt = 0, cplt_cnt = 0;
    int   prev_ss = 0, last_cplt = 0;
    logic have_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pulse_complete) begin
                cplt_cnt++;
                last_cplt = cyc;
            end
            if (shift_start) begin
                ss_cnt++;
                if (have_prev) check("shift_period", cyc - prev_ss, exp_period);
                have_prev = 1'b1;
                prev_ss   = cyc;
                if (exp_ss_q.size() == 0) check("shift_unexpected", 1, 0);
                else check("shift_row_plane", {shift_row, shift_plane}, exp_ss_q.pop_front());
            end
            if (latch) begin
                lat_cnt++;
                check("latch_delay", cyc - prev_ss, exp_sl);
                check("latch_oe_n", oe_n, 1);
                if (exp_row_q.size() == 0) check("latch_unexpected", 1, 0);
                else check("latch_row_addr", row_addr, exp_row_q.pop_front());
            end
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_delay", cyc - last_cplt, 1);
            end
        end
    end

    typedef struct {
        int d;
        int len;
        int frames;
        int period;
        int sl;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic start_run(input int d, input int len, input int frames,
                             input int period, input int sl, input logic fsel);
        mon_en = 1'b0;
        rst    = 1'b1;
        enable = 1'b0;
        step();
        step();
        sh_delay   = d;
        pulse_len  = len;
        force_sel  = fsel;
        exp_period = period;
        exp_sl     = sl;
        exp_ss_q.delete();
        exp_row_q.delete();
        ss_cnt = 0; lat_cnt = 0; fd_cnt = 0; cplt_cnt = 0; have_prev = 1'b0;
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < ROWS; r++)
                for (int p = 0; p < BITS; p++) begin
                    exp_ss_q.push_back(r * 2 + p);
                    exp_row_q.push_back(r);
                end
        mon_en = 1'b1;
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    // mode 0: plain, 1: shift_done hold-off window, 2: forced pulse_select mismatch
    task automatic run_frames(input int d, input int len, input int frames,
                              input int period, input int sl, input int mode);
        logic finished = 1'b0;
        int   go_bad = 0, hold_cnt = 0, hold_bad = 0, dark_bad = 0;
        logic saw_low = 1'b0;
        start_run(d, len, frames, period, sl, mode == 2);
        for (int i = 0; i < 4000; i++) begin
            step();
            if (lat_cnt >= (frames - 1) * PLANES + 3) enable = 1'b0;
            if (mode != 2 && pulse_go && oe_n) go_bad++;
            if (mode == 1 && ss_cnt == 2 && hold_cnt < 20) begin
                hold_cnt++;
                if (oe_n !== 1'b0 || latch !== 1'b0) hold_bad++;
            end
            if (mode == 2) begin
                if (cplt_cnt >= 1) force_sel = 1'b0;
                if (cplt_cnt >= 1 && fd_cnt == 0 && oe_n !== 1'b1) dark_bad++;
                if (fd_cnt >= 1 && oe_n === 1'b0) saw_low = 1'b1;
            end
            if (fd_cnt == frames && !busy) begin
                finished = 1'b1;
                break;
            end
        end
        check("run_finished", finished, 1);
        check("frame_done_count", fd_cnt, frames);
        check("shift_start_count", ss_cnt, frames * PLANES);
        check("shift_queue_left", exp_ss_q.size(), 0);
        check("latch_queue_left", exp_row_q.size(), 0);
        check("idle_oe_n", oe_n, 1);
        check("idle_busy", busy, 0);
        if (mode != 2) check("display_oe_low", go_bad, 0);
        if (mode == 1) begin
            check("holdoff_samples", hold_cnt, 20);
            check("holdoff_oe_low_no_latch", hold_bad, 0);
        end
`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
        if (mode == 2) begin
            check("sync_error_set", sync_error, 1);
            check("sync_blanked_until_frame_end", dark_bad, 0);
            check("sync_display_resumes", saw_low, 1);
        end
`endif
    endtask

    initial begin
        vecs[0] = '{d: 2, len: 3, frames: 1, period: 11, sl: 6};
        vecs[1] = '{d: 0, len: 0, frames: 2, period: 6,  sl: 4};
        vecs[2] = '{d: 5, len: 2, frames: 1, period: 13, sl: 9};
        vecs[3] = '{d: 1, len: 7, frames: 2, period: 14, sl: 5};

        step();
        step();
        check("rst_shift_start", shift_start, 0);
        check("rst_pulse_go", pulse_go, 0);
        check("rst_latch", latch, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_shift_pos", {shift_row, shift_plane}, 0);

        // first shift_start appears the cycle after enable is seen in IDLE
        rst = 1'b0;
        enable = 1'b1;
        step();
        check("first_shift_start", shift_start, 1);
        check("first_busy", busy, 1);

        for (int i = 0; i < 4; i++)
            run_frames(vecs[i].d, vecs[i].len, vecs[i].frames, vecs[i].period, vecs[i].sl, 0);

        run_frames(20, 2, 1, 28, 24, 1);

        // reset pulsed during a row-1 DISPLAY
        begin
            logic hit = 1'b0;
            start_run(1, 3, 1, 10, 5, 1'b0);
            for (int i = 0; i < 1000; i++) begin
                step();
                if (lat_cnt == 3 && pulse_go) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("reached_row1_display", hit, 1);
            mon_en = 1'b0;
            rst = 1'b1;
            step();
            check("midrst_pulse_go", pulse_go, 0);
            check("midrst_oe_n", oe_n, 1);
            check("midrst_row_addr", row_addr, 0);
            check("midrst_shift_pos", {shift_row, shift_plane}, 0);
            check("midrst_busy", busy, 0);
            run_frames(1, 3, 1, 10, 5, 0);
        end

`ifdef DISPLAY_SCAN_SYNC_CHECK_EN
        run_frames(1, 2, 2, 9, 5, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
